// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects, multiply FSM states
// and the decoded control bundle carried through the pipeline registers.
package execute_stage_pkg;

  typedef enum logic [2:0] {
    AluAnd  = 3'b000,
    AluOr   = 3'b001,
    AluAdd  = 3'b010,
    AluNone = 3'b011,
    AluMflo = 3'b100,
    AluMfhi = 3'b101,
    AluSub  = 3'b110,
    AluSlt  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FwdReg     = 2'b00,
    FwdResultW = 2'b01,
    FwdAluOutM = 2'b10,
    FwdRegAlt  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulBusy = 2'd1,
    MulDone = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       mult;
    logic [2:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side inputs, forwarding controls and E/M-stage outputs of the execute stage.
interface execute_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, MultD;
    logic [2:0]       ALUControlD;
    logic [WIDTH-1:0] RD1D, RD2D, SignImmD, ResultW;
    logic [4:0]       RsD, RtD, RdD;
    logic             RegWriteE, MemtoRegE;
    logic [4:0]       RsE, RtE, WriteRegE;
    logic             RegWriteM, MemtoRegM, MemWriteM;
    logic [WIDTH-1:0] ALUOutM, WriteDataM;
    logic [4:0]       WriteRegM;
    logic             BusyE;

    modport master (
        output FlushE, ForwardAE, ForwardBE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
               RegDstD, MultD, ALUControlD, RD1D, RD2D, SignImmD, ResultW, RsD, RtD, RdD,
        input  RegWriteE, MemtoRegE, RsE, RtE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM,
               ALUOutM, WriteDataM, WriteRegM, BusyE
    );

    modport slave (
        input  FlushE, ForwardAE, ForwardBE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
               RegDstD, MultD, ALUControlD, RD1D, RD2D, SignImmD, ResultW, RsD, RtD, RdD,
        output RegWriteE, MemtoRegE, RsE, RtE, WriteRegE, RegWriteM, MemtoRegM, MemWriteM,
               ALUOutM, WriteDataM, WriteRegM, BusyE
    );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU; hi/lo feed MFHI/MFLO and are tied to zero when no multiplier exists.
module alu
    import execute_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        unique case (alu_op_e'(alu_ctrl))
            AluAnd:  y = a & b;
            AluOr:   y = a | b;
            AluAdd:  y = a + b;
            AluNone: y = '0;
            AluMflo: y = lo;
            AluMfhi: y = hi;
            AluSub:  y = a - b;
            AluSlt:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: ID/EX and EX/MEM registers, forwarding, ALU and an optional
// shift-add multiplier with HI/LO, enabled by defining MULT_UNIT_EN.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    execute_stage_if.slave bus
);
    ctrl_t            ctrl_d, ctrl_e_q, ctrl_m_q;
    logic [WIDTH-1:0] rd1_e_q, rd2_e_q, imm_e_q;
    logic [4:0]       rs_e_q, rt_e_q, rd_e_q, write_reg_e, write_reg_m_q;
    logic [WIDTH-1:0] src_a, src_b, alu_b, alu_y, alu_out_m_q, write_data_m_q;
    logic [WIDTH-1:0] hi, lo;
    logic             busy;

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.reg_write  = bus.RegWriteD;
        ctrl_d.mem_to_reg = bus.MemtoRegD;
        ctrl_d.mem_write  = bus.MemWriteD;
        ctrl_d.alu_src    = bus.ALUSrcD;
        ctrl_d.reg_dst    = bus.RegDstD;
`ifdef MULT_UNIT_EN
        ctrl_d.mult       = bus.MultD;
`endif
        ctrl_d.alu_ctrl   = bus.ALUControlD;
    end

    // A running multiply freezes the instruction in E; flush is ignored until it ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e_q <= '0;
            rd1_e_q  <= '0;
            rd2_e_q  <= '0;
            imm_e_q  <= '0;
            rs_e_q   <= '0;
            rt_e_q   <= '0;
            rd_e_q   <= '0;
        end else if (!busy) begin
            rd1_e_q <= bus.RD1D;
            rd2_e_q <= bus.RD2D;
            imm_e_q <= bus.SignImmD;
            if (bus.FlushE) begin
                ctrl_e_q <= '0;
                rs_e_q   <= '0;
                rt_e_q   <= '0;
                rd_e_q   <= '0;
            end else begin
                ctrl_e_q <= ctrl_d;
                rs_e_q   <= bus.RsD;
                rt_e_q   <= bus.RtD;
                rd_e_q   <= bus.RdD;
            end
        end
    end

    always_comb begin
        case (fwd_sel_e'(bus.ForwardAE))
            FwdResultW: src_a = bus.ResultW;
            FwdAluOutM: src_a = alu_out_m_q;
            default:    src_a = rd1_e_q;
        endcase
        case (fwd_sel_e'(bus.ForwardBE))
            FwdResultW: src_b = bus.ResultW;
            FwdAluOutM: src_b = alu_out_m_q;
            default:    src_b = rd2_e_q;
        endcase
    end

    assign alu_b       = ctrl_e_q.alu_src ? imm_e_q : src_b;
    assign write_reg_e = ctrl_e_q.reg_dst ? rd_e_q : rt_e_q;

    alu #(.WIDTH(WIDTH)) u_alu (
        .alu_ctrl (ctrl_e_q.alu_ctrl),
        .a        (src_a),
        .b        (alu_b),
        .hi       (hi),
        .lo       (lo),
        .y        (alu_y)
    );

`ifdef MULT_UNIT_EN
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e         state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q, hi_q, lo_q;

    // One partial product per BUSY cycle, LSB of the multiplier first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MulIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                MulIdle: begin
                    if (ctrl_e_q.mult) begin
                        state_q  <= MulBusy;
                        cnt_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, src_a};
                        mplier_q <= src_b;
                        acc_q    <= '0;
                    end
                end
                MulBusy: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= MulDone;
                end
                MulDone: begin
                    {hi_q, lo_q} <= acc_q;
                    state_q      <= MulIdle;
                end
                default: state_q <= MulIdle;
            endcase
        end
    end

    assign busy = (state_q == MulBusy);
    assign hi   = hi_q;
    assign lo   = lo_q;
`else
    assign busy = 1'b0;
    assign hi   = '0;
    assign lo   = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset || busy) begin
            ctrl_m_q       <= '0;
            alu_out_m_q    <= '0;
            write_data_m_q <= '0;
            write_reg_m_q  <= '0;
        end else begin
            ctrl_m_q       <= ctrl_e_q;
            alu_out_m_q    <= alu_y;
            write_data_m_q <= src_b;
            write_reg_m_q  <= write_reg_e;
        end
    end

    assign bus.RegWriteE  = ctrl_e_q.reg_write;
    assign bus.MemtoRegE  = ctrl_e_q.mem_to_reg;
    assign bus.RsE        = rs_e_q;
    assign bus.RtE        = rt_e_q;
    assign bus.WriteRegE  = write_reg_e;
    assign bus.RegWriteM  = ctrl_m_q.reg_write;
    assign bus.MemtoRegM  = ctrl_m_q.mem_to_reg;
    assign bus.MemWriteM  = ctrl_m_q.mem_write;
    assign bus.ALUOutM    = alu_out_m_q;
    assign bus.WriteDataM = write_data_m_q;
    assign bus.WriteRegM  = write_reg_m_q;
    assign bus.BusyE      = busy;
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; multiply scenarios run when MULT_UNIT_EN
// is defined, otherwise the bench checks that the multiplier is absent.
module tb_execute_stage;
    logic clk = 1'b0;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    execute_stage_if #(.WIDTH(32)) bus ();

    execute_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.FlushE = 0; bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0;
        bus.ALUSrcD = 0; bus.RegDstD = 0; bus.MultD = 0; bus.ALUControlD = 3'b000;
        bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0; bus.RsD = 0; bus.RtD = 0; bus.RdD = 0;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        idle();
        bus.ALUControlD = op;
        bus.RD1D = a;
        bus.RD2D = b;
    endtask

    task automatic test_reset;
        logic [111:0] outs;
        reset = 1;
        idle();
        bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 32'h1234;
        bus.RegWriteD = 1; bus.MemWriteD = 1; bus.RD1D = 32'hAAAA; bus.RsD = 5'd7;
        bus.RdD = 5'd9; bus.RegDstD = 1; bus.ALUControlD = 3'b010;
        step();
        step();
        outs = {bus.RegWriteE, bus.MemtoRegE, bus.RsE, bus.RtE, bus.WriteRegE, bus.RegWriteM,
                bus.MemtoRegM, bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, bus.WriteRegM,
                bus.BusyE};
        vec_cnt++;
        if (outs !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 0;
        idle();
        step();
    endtask

    task automatic test_add;
        drive_op(3'b010, 32'd5, 32'd7);
        bus.RegWriteD = 1; bus.RegDstD = 1; bus.RsD = 5'd3; bus.RtD = 5'd4; bus.RdD = 5'd9;
        step();
        vec_cnt++;
        if ({bus.RegWriteE, bus.RsE, bus.RtE, bus.WriteRegE} !== {1'b1, 5'd3, 5'd4, 5'd9}) begin
            err_cnt++;
            $display("FAIL add_e_stage: got %b %0d %0d %0d expected 1 3 4 9",
                     bus.RegWriteE, bus.RsE, bus.RtE, bus.WriteRegE);
        end
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'd12 || bus.WriteDataM !== 32'd7 || bus.WriteRegM !== 5'd9 ||
            bus.RegWriteM !== 1'b1) begin
            err_cnt++;
            $display("FAIL add_m_stage: got alu=%h wd=%h wr=%0d rw=%b expected 0000000c 00000007 9 1",
                     bus.ALUOutM, bus.WriteDataM, bus.WriteRegM, bus.RegWriteM);
        end
    endtask

    task automatic test_alu_ops;
        logic [2:0]  ops [11] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b110, 3'b111, 3'b111,
                                  3'b111, 3'b011, 3'b100, 3'b101};
        logic [31:0] as  [11] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_FFFF, 32'd0, 32'd10,
                                  32'hFFFF_FFFF, 32'd1, 32'd5, 32'd6, 32'd9, 32'd9};
        logic [31:0] bs  [11] = '{32'h0FF0_FF00, 32'h0000_000F, 32'd2, 32'd1, 32'd3, 32'd1,
                                  32'hFFFF_FFFF, 32'd5, 32'd7, 32'd9, 32'd9};
        logic [31:0] exp [11] = '{32'h00F0_1200, 32'hF000_000F, 32'd1, 32'hFFFF_FFFF, 32'd7,
                                  32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 11; i++) begin
            drive_op(ops[i], as[i], bs[i]);
            step();
            idle();
            step();
            vec_cnt++;
            if (bus.ALUOutM !== exp[i]) begin
                err_cnt++;
                $display("FAIL alu_op[%0d] op=%b: got %h expected %h", i, ops[i], bus.ALUOutM,
                         exp[i]);
            end
        end
        drive_op(3'b010, 32'd1, 32'd5);
        bus.ALUSrcD = 1; bus.SignImmD = 32'h100;
        step();
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'h101 || bus.WriteDataM !== 32'd5) begin
            err_cnt++;
            $display("FAIL alu_src_imm: got alu=%h wd=%h expected 00000101 00000005",
                     bus.ALUOutM, bus.WriteDataM);
        end
    endtask

    task automatic test_forward;
        drive_op(3'b010, 32'h8, 32'h8);
        step();
        drive_op(3'b110, 32'h99, 32'h77);
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'h10) begin
            err_cnt++;
            $display("FAIL fwd_setup: got %h expected 00000010", bus.ALUOutM);
        end
        bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'd3;
        drive_op(3'b001, 32'h0, 32'h0);
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'hD || bus.WriteDataM !== 32'd3) begin
            err_cnt++;
            $display("FAIL fwd_a_m_b_w: got alu=%h wd=%h expected 0000000d 00000003",
                     bus.ALUOutM, bus.WriteDataM);
        end
        bus.ForwardAE = 2'b01; bus.ForwardBE = 2'b10; bus.ResultW = 32'h20;
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'h2D) begin
            err_cnt++;
            $display("FAIL fwd_a_w_b_m: got %h expected 0000002d", bus.ALUOutM);
        end
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
        drive_op(3'b010, 32'd2, 32'd3);
        step();
        bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11; bus.ResultW = 32'h100;
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'd5) begin
            err_cnt++;
            $display("FAIL fwd_11_is_reg: got %h expected 00000005", bus.ALUOutM);
        end
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.ResultW = 32'h0;
    endtask

    task automatic test_controls;
        drive_op(3'b010, 32'd1, 32'd2);
        bus.MemtoRegD = 1; bus.MemWriteD = 1; bus.RegWriteD = 1; bus.RegDstD = 0;
        bus.RtD = 5'd17; bus.RdD = 5'd22; bus.RsD = 5'd30;
        step();
        vec_cnt++;
        if ({bus.MemtoRegE, bus.WriteRegE, bus.RsE} !== {1'b1, 5'd17, 5'd30}) begin
            err_cnt++;
            $display("FAIL ctrl_e_stage: got %b %0d %0d expected 1 17 30",
                     bus.MemtoRegE, bus.WriteRegE, bus.RsE);
        end
        idle();
        step();
        vec_cnt++;
        if ({bus.MemtoRegM, bus.MemWriteM, bus.RegWriteM, bus.WriteRegM} !==
            {1'b1, 1'b1, 1'b1, 5'd17}) begin
            err_cnt++;
            $display("FAIL ctrl_m_stage: got %b %b %b %0d expected 1 1 1 17",
                     bus.MemtoRegM, bus.MemWriteM, bus.RegWriteM, bus.WriteRegM);
        end
    endtask

    task automatic test_flush;
        drive_op(3'b010, 32'd4, 32'd4);
        bus.RegWriteD = 1; bus.MemWriteD = 1; bus.MemtoRegD = 1; bus.RegDstD = 1;
        bus.RsD = 5'd1; bus.RtD = 5'd2; bus.RdD = 5'd3; bus.FlushE = 1;
        step();
        vec_cnt++;
        if ({bus.RegWriteE, bus.MemtoRegE, bus.RsE, bus.RtE, bus.WriteRegE} !== '0) begin
            err_cnt++;
            $display("FAIL flush_e_stage: got %b %b %0d %0d %0d expected all 0", bus.RegWriteE,
                     bus.MemtoRegE, bus.RsE, bus.RtE, bus.WriteRegE);
        end
        idle();
        step();
        vec_cnt++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WriteRegM} !== '0) begin
            err_cnt++;
            $display("FAIL flush_m_stage: got %b %b %b %0d expected all 0", bus.RegWriteM,
                     bus.MemWriteM, bus.MemtoRegM, bus.WriteRegM);
        end
    endtask

`ifdef MULT_UNIT_EN
    task automatic test_mult;
        int n = 0;
        drive_op(3'b000, 32'hFFFF_FFFF, 32'd2);
        bus.MultD = 1;
        step();
        idle();
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.BusyE === 1'b1) n++;
            else if (n > 0) break;
        end
        vec_cnt++;
        if (n != 32) begin
            err_cnt++;
            $display("FAIL mult_busy_cycles: got %0d expected 32", n);
        end
        drive_op(3'b101, 32'd0, 32'd0);
        step();
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'd1) begin
            err_cnt++;
            $display("FAIL mult_mfhi: got %h expected 00000001", bus.ALUOutM);
        end
        drive_op(3'b100, 32'd0, 32'd0);
        step();
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'hFFFF_FFFE) begin
            err_cnt++;
            $display("FAIL mult_mflo: got %h expected fffffffe", bus.ALUOutM);
        end
    endtask

    task automatic test_mult_reset;
        int n = 0;
        drive_op(3'b000, 32'hFFFF_FFFF, 32'd2);
        bus.MultD = 1;
        step();
        idle();
        for (int i = 0; i < 20 && n < 10; i++) begin
            step();
            if (bus.BusyE === 1'b1) n++;
        end
        reset = 1;
        step();
        reset = 0;
        vec_cnt++;
        if (bus.BusyE !== 1'b0 || n != 10) begin
            err_cnt++;
            $display("FAIL mult_reset_busy: got busy=%b cycles=%0d expected 0 10", bus.BusyE, n);
        end
        drive_op(3'b101, 32'd0, 32'd0);
        step();
        idle();
        step();
        vec_cnt++;
        if (bus.ALUOutM !== 32'd0) begin
            err_cnt++;
            $display("FAIL mult_reset_hi: got %h expected 00000000", bus.ALUOutM);
        end
    endtask
`else
    task automatic test_no_mult;
        drive_op(3'b010, 32'd1, 32'd1);
        bus.MultD = 1;
        step();
        idle();
        vec_cnt++;
        if (bus.BusyE !== 1'b0) begin
            err_cnt++;
            $display("FAIL no_mult_busy_e: got %b expected 0", bus.BusyE);
        end
        step();
        vec_cnt++;
        if (bus.BusyE !== 1'b0 || bus.ALUOutM !== 32'd2) begin
            err_cnt++;
            $display("FAIL no_mult_pass: got busy=%b alu=%h expected 0 00000002", bus.BusyE,
                     bus.ALUOutM);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_forward();
        test_controls();
        test_flush();
`ifdef MULT_UNIT_EN
        test_mult();
        test_mult_reset();
`else
        test_no_mult();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the datapath width.
REQ-002 The module SHALL have port clk, input, 1 bit, the sole clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port FlushE, input, 1 bit: load a bubble into the ID/EX register.
REQ-005 The module SHALL have ports ForwardAE and ForwardBE, input, 2 bits each: operand select, 00 = register, 01 = ResultW, 10 = ALUOutM, 11 = register.
REQ-006 The module SHALL have ports RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD and MultD, input, 1 bit each: decode controls.
REQ-007 The module SHALL have port ALUControlD, input, 3 bits: ALU operation.
REQ-008 The module SHALL have ports RD1D, RD2D and SignImmD, input, WIDTH bits each.
REQ-009 The module SHALL have ports RsD, RtD and RdD, input, 5 bits each.
REQ-010 The module SHALL have port ResultW, input, WIDTH bits: writeback forward value.
REQ-011 The module SHALL have ports RegWriteE and MemtoRegE, output, 1 bit each, and RsE, RtE and WriteRegE, output, 5 bits each, to the hazard unit.
REQ-012 The module SHALL have ports RegWriteM, MemtoRegM and MemWriteM, output, 1 bit each.
REQ-013 The module SHALL have ports ALUOutM and WriteDataM, output, WIDTH bits each, and WriteRegM, output, 5 bits.
REQ-014 The module SHALL have port BusyE, output, 1 bit: multiply in progress, which stalls F/D/E.

Function
REQ-015 The ID/EX register SHALL capture all D inputs each cycle; with FlushE=1 it SHALL instead zero the controls and register numbers (bubble), and data fields are don't-care.
REQ-016 WriteRegE SHALL be RdE when RegDstE=1, else RtE.
REQ-017 SrcAE and SrcBE SHALL be the forwarding-mux outputs; the ALU B operand SHALL be SignImmE when ALUSrcE=1, else SrcBE.
REQ-018 ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1/0), 100 MFLO, 101 MFHI; code 011 SHALL yield 0; arithmetic SHALL wrap modulo 2^WIDTH.
REQ-019 The EX/MEM register SHALL capture ALU result, SrcBE (as WriteDataM), WriteRegE and controls every cycle; latency D to M is 2 cycles.
REQ-020 ALUOutM SHALL be the registered value, fed back internally as forward source 10.
REQ-021 While BusyE=1, the ID/EX register SHALL hold (ignore D inputs and FlushE) and the EX/MEM register SHALL load a bubble.
REQ-022 Forwarding SHALL take effect in the same cycle as ForwardAE/BE; the 11 encoding SHALL be treated as 00.

Reset
REQ-023 While reset=1, both pipeline registers, HI, LO, the FSM and the counter SHALL clear to 0, and every output SHALL read 0 on the next cycle.
REQ-024 A reset during a multiply SHALL abort it; HI/LO SHALL be 0 and the state SHALL be IDLE.

Configuration
REQ-025 With MULT_UNIT_EN defined, a multiply SHALL start when MultE=1 in IDLE; the unit is unsigned shift-add and runs for 32 BUSY cycles, then DONE writes the 64-bit product to {HI,LO} and the FSM returns to IDLE.
REQ-026 BusyE SHALL be 1 in BUSY and 0 in IDLE and DONE; MultE SHALL not re-trigger until IDLE.
REQ-027 Without MULT_UNIT_EN, MultD SHALL be ignored, BusyE SHALL be tied to 0, HI/LO SHALL not exist and codes 100/101 SHALL yield 0.

Structure
REQ-028 A shared package SHALL hold the ALU op encodings, the forward-select encodings and the multiply-FSM state enum.
REQ-029 The ALU SHALL be a combinational sub-module named alu; the multiply FSM SHALL stay inline.

Verification
REQ-030 ADD: RD1D=5, RD2D=7, ALUControlD=010 -> ALUOutM=12 two cycles later.
REQ-031 Forwarding: ForwardAE=10 with ALUOutM=0x10, and ForwardBE=01 with ResultW=3, ALUControl=110 -> next ALUOutM=0xD.
REQ-032 Flush: FlushE=1 with RegWriteD=1 -> RegWriteE=0 and RegWriteM=0 one cycle later.
REQ-033 SLT: 0xFFFFFFFF vs 1 -> 1; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-034 MULT_UNIT_EN: 0xFFFFFFFF*2 -> BusyE high for 32 cycles; MFHI gives 1 and MFLO gives 0xFFFFFFFE.
REQ-035 Reset on BUSY cycle 10 -> BusyE=0 next cycle, and MFHI returns 0.
